instr_reg_ctrl: RTL and testbench
=================================

# instr_reg_ctrl

Controller that shares the 32-entry instruction register between two instruction sources and sequences its write/read pointers as a FIFO. It arbitrates requests from two requesters, drives `load_en`, `opcode`, `operand_a`, `operand_b` and `write_pointer` into the register, and advances `read_pointer` as a downstream consumer accepts completed instruction words. It sits directly between the testbench/requester agents and `instr_register`, with both sharing one clock and reset.

## Interface
- No parameters; depth fixed at 32 (`address_t` is 5 bits).
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0_valid`, `req1_valid`  in  1 each  requester has an instruction
- `req0_ready`, `req1_ready`  out  1 each  instruction accepted this cycle when valid&ready
- `req0_opcode`, `req1_opcode`  in  opcode_t  requested operation
- `req0_operand_a/b`, `req1_operand_a/b`  in  operand_t  requested operands
- `load_en`  out  1  write strobe to register
- `opcode`, `operand_a`, `operand_b`  out  opcode_t/operand_t  winning request, to register
- `write_pointer`, `read_pointer`  out  address_t  register pointers
- `rd_valid`  out  1  entry at `read_pointer` is written and unread
- `rd_ready`  in  1  consumer takes `instruction_word` from the register this cycle
- `count`  out  6  number of written, unread entries (0..32)

## Operation
- FSM states: EMPTY (count==0), RUN (1..31), FULL (count==32); state register is the source of `rd_valid` and ready gating.
- Arbitration: when not FULL, at most one requester is granted per cycle; grant is a combinational function of valids and the `last_grant` flop.
- Round-robin: if both valid, the requester not granted last is granted; `last_grant` updates only on an actual grant; reset value selects req0 first.
- `reqN_ready` = grant to N; never both high; both low in FULL.
- `load_en` = any grant; `opcode/operand_a/operand_b` mux the granted requester; when `load_en` is low they drive the last granted values (held, no X).
- Write: on a grant edge, `write_pointer` increments, wrapping 31→0.
- Read: `rd_valid` = state != EMPTY; on `rd_valid & rd_ready`, `read_pointer` increments, wrapping 31→0; `rd_ready` without `rd_valid` is ignored.
- `count`: +1 on write only, −1 on read only, unchanged on simultaneous write and read.
- Transitions: EMPTY→RUN on write; RUN→FULL on write-only at count 31; RUN→EMPTY on read-only at count 1; FULL→RUN on read; otherwise hold.
- A simultaneous write and read in FULL cannot occur (ready low); in EMPTY only the write takes effect.

## Timing
- Reset (async assert, sync release): state EMPTY, count 0, both pointers 0, `load_en` 0, readies 0, `rd_valid` 0, held operands/opcode 0/ZERO, `last_grant` = req1 so req0 wins first.
- Handshake to write: zero latency; the register captures on the same edge the handshake completes.
- Write to `rd_valid`: 1 cycle (asserted the cycle after the write edge when previously EMPTY).
- Sustained throughput: one write and one read per cycle.
- Reset mid-operation: pointers and count are cleared immediately; in-flight handshakes are discarded; the register is cleared by the same `reset_n`.
- `valid` may drop without acceptance; the controller imposes no hold requirement on requesters.

## Configuration
- `CTRL_FIXED_PRIORITY_EN`: when defined, req0 always wins when both requesters are valid; `last_grant` is not implemented.
- Without the macro: round-robin as above.

## Structure
- Shared package `instr_register_pkg`: existing `opcode_t`, `operand_t`, `address_t`, `instruction_t`; add `ctrl_state_t` (EMPTY, RUN, FULL) and the `IR_DEPTH = 32` constant.
- One sub-module: `rr_arbiter2` (2-way grant plus `last_grant` flop, honouring `CTRL_FIXED_PRIORITY_EN`); pointers, count and the FSM stay in `instr_reg_ctrl`.

## Test plan
- Reset, then req0 ADD a=5 b=3 -> `load_en` 1, `write_pointer` 0→1, next cycle `rd_valid` 1; on `rd_ready`, `instruction_word` result 8 and `read_pointer` 1, state EMPTY.
- Both valid for 4 cycles, no reads -> grants 0,1,0,1, `count` 4; with `CTRL_FIXED_PRIORITY_EN` -> grants 0,0,0,0.
- 32 writes, no reads -> FULL, both readies 0 while valid; one read -> FULL→RUN, next write accepted to `write_pointer` 0 (wrap).
- Full wrap: 40 writes interleaved with reads -> `read_pointer` and `write_pointer` wrap 31→0, results in order, `count` never exceeds 32.
- Simultaneous write and read at count 5 -> `count` stays 5, both pointers +1.
- Assert `reset_n` low at count 10 with req0 valid -> all outputs return to reset values immediately, `rd_valid` 0, no write occurs.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its controller.
// Holds opcode/operand/address types, controller state and depth.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef logic [4:0] address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        EMPTY,
        RUN,
        FULL
    } ctrl_state_t;

    localparam int IR_DEPTH = 32;

    // Pointer advance; the 5-bit width gives the 31->0 wrap for free.
    function automatic address_t ptr_inc(input address_t p);
        return p + 5'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter with a last-grant flop for round-robin.
// Ports: en_i gate, req0_i/req1_i, gnt0_o/gnt1_o (one-hot or zero).
// Define CTRL_FIXED_PRIORITY_EN for fixed req0-first priority.
module rr_arbiter2 (
`ifndef CTRL_FIXED_PRIORITY_EN
    input  logic clk,
    input  logic reset_n,
`endif
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

`ifdef CTRL_FIXED_PRIORITY_EN

    assign gnt0_o = en_i & req0_i;
    assign gnt1_o = en_i & req1_i & ~req0_i;

`else

    // 1 means req1 was granted last; reset to 1 so req0 wins first.
    logic last_q;

    assign gnt0_o = en_i & req0_i & (~req1_i | last_q);
    assign gnt1_o = en_i & req1_i & (~req0_i | ~last_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (gnt0_o) begin
            last_q <= 1'b0;
        end else if (gnt1_o) begin
            last_q <= 1'b1;
        end
    end

`endif

endmodule

// File: rtl/instr_reg_ctrl.sv
// Controller sharing the 32-entry instruction register between two
// requesters; arbitrates writes and sequences the FIFO pointers.
// Ports: req0/req1 valid/ready + opcode/operands in; load_en, opcode,
// operand_a/b, write_pointer to the register; read_pointer, rd_valid,
// rd_ready, count for the consumer. Macro: CTRL_FIXED_PRIORITY_EN.
module instr_reg_ctrl
    import instr_register_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  opcode_t    req0_opcode,
    input  operand_t   req0_operand_a,
    input  operand_t   req0_operand_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  opcode_t    req1_opcode,
    input  operand_t   req1_operand_a,
    input  operand_t   req1_operand_b,
    output logic       load_en,
    output opcode_t    opcode,
    output operand_t   operand_a,
    output operand_t   operand_b,
    output address_t   write_pointer,
    output address_t   read_pointer,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [5:0] count
);

    localparam logic [5:0] CNT_LAST = 6'(IR_DEPTH - 1);

    ctrl_state_t  state_q;
    address_t     wr_ptr_q;
    address_t     rd_ptr_q;
    logic [5:0]   count_q;
    logic [5:0]   count_d;
    instruction_t held_q;
    instruction_t win;
    logic         gnt0;
    logic         gnt1;
    logic         arb_en;
    logic         wr_en;
    logic         rd_en;

    // Reset also gates grants so readies read 0 while reset_n is low.
    assign arb_en = reset_n & (state_q != FULL);

    rr_arbiter2 u_arb (
`ifndef CTRL_FIXED_PRIORITY_EN
        .clk     (clk),
        .reset_n (reset_n),
`endif
        .en_i    (arb_en),
        .req0_i  (req0_valid),
        .req1_i  (req1_valid),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1)
    );

    assign wr_en = gnt0 | gnt1;
    assign rd_en = rd_valid & rd_ready;

    // Idle cycles replay the last granted request rather than X.
    always_comb begin
        win = held_q;
        if (gnt0) begin
            win = '{opc: req0_opcode,
                    op_a: req0_operand_a,
                    op_b: req0_operand_b};
        end else if (gnt1) begin
            win = '{opc: req1_opcode,
                    op_a: req1_operand_a,
                    op_b: req1_operand_b};
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 6'd1;
            2'b01:   count_d = count_q - 6'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            held_q   <= '{opc: ZERO, op_a: '0, op_b: '0};
        end else begin
            count_q <= count_d;
            if (wr_en) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
                held_q   <= win;
            end
            if (rd_en) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case (state_q)
                EMPTY: begin
                    if (wr_en) state_q <= RUN;
                end
                RUN: begin
                    if (wr_en && !rd_en && count_q == CNT_LAST)
                        state_q <= FULL;
                    else if (rd_en && !wr_en && count_q == 6'd1)
                        state_q <= EMPTY;
                end
                FULL: begin
                    if (rd_en) state_q <= RUN;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign rd_valid      = (state_q != EMPTY);
    assign req0_ready    = gnt0;
    assign req1_ready    = gnt1;
    assign load_en       = wr_en;
    assign opcode        = win.opc;
    assign operand_a     = win.op_a;
    assign operand_b     = win.op_b;
    assign write_pointer = wr_ptr_q;
    assign read_pointer  = rd_ptr_q;
    assign count         = count_q;

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Self-checking bench for instr_reg_ctrl: vector table, directed
// corner sequences and randomized traffic against a FIFO model.
module tb_instr_reg_ctrl;
    import instr_register_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    opcode_t    req0_opcode, req1_opcode;
    operand_t   req0_operand_a, req0_operand_b;
    operand_t   req1_operand_a, req1_operand_b;
    logic       load_en;
    opcode_t    opcode;
    operand_t   operand_a, operand_b;
    address_t   write_pointer, read_pointer;
    logic       rd_valid, rd_ready;
    logic [5:0] count;

    instr_reg_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_opcode    (req0_opcode),
        .req0_operand_a (req0_operand_a),
        .req0_operand_b (req0_operand_b),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_opcode    (req1_opcode),
        .req1_operand_a (req1_operand_a),
        .req1_operand_b (req1_operand_b),
        .load_en        (load_en),
        .opcode         (opcode),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .write_pointer  (write_pointer),
        .read_pointer   (read_pointer),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy, pointers, last grantee, held word.
    int       m_cnt, m_wp, m_rp, m_last;
    int       m_hop;
    operand_t m_ha, m_hb;
    int       fq[$];
    logic     e_g0, e_g1, e_rd;

    typedef struct {
        logic v0;
        logic v1;
        logic rr;
        logic g0;
        logic g1;
        int   cnt;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wp = 0; m_rp = 0; m_last = 1;
        m_hop = 0; m_ha = '0; m_hb = '0;
        fq.delete();
    endtask

    task automatic predict();
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (m_cnt < IR_DEPTH) begin
            if (req0_valid && req1_valid) begin
`ifdef CTRL_FIXED_PRIORITY_EN
                e_g0 = 1'b1;
`else
                if (m_last == 1) e_g0 = 1'b1;
                else e_g1 = 1'b1;
`endif
            end else if (req0_valid) begin
                e_g0 = 1'b1;
            end else if (req1_valid) begin
                e_g1 = 1'b1;
            end
        end
        e_rd = (m_cnt > 0) && rd_ready;
    endtask

    task automatic check_all();
        int eop;
        operand_t ea, eb;
        predict();
        eop = m_hop; ea = m_ha; eb = m_hb;
        if (e_g0) begin
            eop = int'(req0_opcode); ea = req0_operand_a; eb = req0_operand_b;
        end else if (e_g1) begin
            eop = int'(req1_opcode); ea = req1_operand_a; eb = req1_operand_b;
        end
        chk("req0_ready", 32'(req0_ready), 32'(e_g0));
        chk("req1_ready", 32'(req1_ready), 32'(e_g1));
        chk("load_en", 32'(load_en), 32'(e_g0 | e_g1));
        chk("opcode", 32'(opcode), 32'(eop));
        chk("operand_a", operand_a, ea);
        chk("operand_b", operand_b, eb);
        chk("write_pointer", 32'(write_pointer), 32'(m_wp));
        chk("read_pointer", 32'(read_pointer), 32'(m_rp));
        chk("rd_valid", 32'(rd_valid), 32'(m_cnt > 0));
        chk("count", 32'(count), 32'(m_cnt));
        if (e_rd) chk("read_order", 32'(read_pointer), 32'(fq[0]));
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_g0 || e_g1) begin
            fq.push_back(m_wp);
            m_wp = (m_wp + 1) % IR_DEPTH;
            m_last = e_g1 ? 1 : 0;
            if (e_g0) begin
                m_hop = int'(req0_opcode); m_ha = req0_operand_a;
                m_hb = req0_operand_b;
            end else begin
                m_hop = int'(req1_opcode); m_ha = req1_operand_a;
                m_hb = req1_operand_b;
            end
            m_cnt++;
        end
        if (e_rd) begin
            void'(fq.pop_front());
            m_rp = (m_rp + 1) % IR_DEPTH;
            m_cnt--;
        end
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic rr);
        req0_valid     = v0;
        req1_valid     = v1;
        rd_ready       = rr;
        req0_opcode    = opcode_t'(4'($urandom_range(0, 7)));
        req1_opcode    = opcode_t'(4'($urandom_range(0, 7)));
        req0_operand_a = operand_t'($urandom);
        req0_operand_b = operand_t'($urandom);
        req1_operand_a = operand_t'($urandom);
        req1_operand_b = operand_t'($urandom);
    endtask

    task automatic cycle(input logic v0, input logic v1, input logic rr);
        drive(v0, v1, rr);
        #4;
        check_all();
        advance();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1, 1, 0, 1, 0, 0};
`ifdef CTRL_FIXED_PRIORITY_EN
        tbl[1] = '{1, 1, 0, 1, 0, 1};
        tbl[3] = '{1, 1, 0, 1, 0, 3};
`else
        tbl[1] = '{1, 1, 0, 0, 1, 1};
        tbl[3] = '{1, 1, 0, 0, 1, 3};
`endif
        tbl[2] = '{1, 1, 0, 1, 0, 2};
        tbl[4] = '{0, 0, 1, 0, 0, 4};
        tbl[5] = '{0, 1, 1, 0, 1, 3};
        tbl[6] = '{1, 0, 0, 1, 0, 3};
        tbl[7] = '{0, 0, 0, 0, 0, 4};

        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        #4;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'(ZERO));
        chk("rst_wp", 32'(write_pointer), 32'd0);

        // First write then read.
        drive(1'b1, 1'b0, 1'b0);
        req0_opcode = ADD; req0_operand_a = 5; req0_operand_b = 3;
        #4;
        chk("t1_load_en", 32'(load_en), 32'd1);
        chk("t1_opcode", 32'(opcode), 32'(ADD));
        check_all();
        advance();
        drive(1'b0, 1'b0, 1'b0);
        #4;
        chk("t1_wp", 32'(write_pointer), 32'd1);
        chk("t1_rd_valid", 32'(rd_valid), 32'd1);
        chk("t1_hold_a", operand_a, 32'd5);
        check_all();
        advance();
        drive(1'b0, 1'b0, 1'b1);
        #4;
        check_all();
        advance();
        chk("t1_rp", 32'(read_pointer), 32'd1);
        chk("t1_empty", 32'(rd_valid), 32'd0);

        // Arbitration vector table.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v0, tbl[i].v1, tbl[i].rr);
            #4;
            chk($sformatf("tbl%0d_g0", i), 32'(req0_ready), 32'(tbl[i].g0));
            chk($sformatf("tbl%0d_g1", i), 32'(req1_ready), 32'(tbl[i].g1));
            chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].cnt));
            check_all();
            advance();
        end

        // Fill to FULL, readies blocked, one read, wrap on next write.
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        #4;
        chk("full_cnt", 32'(count), 32'd32);
        chk("full_rdy0", 32'(req0_ready), 32'd0);
        chk("full_rdy1", 32'(req1_ready), 32'd0);
        check_all();
        advance();
        cycle(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        #4;
        chk("wrap_rdy0", 32'(req0_ready), 32'd1);
        chk("wrap_wp", 32'(write_pointer), 32'd0);
        check_all();
        advance();

        // Simultaneous write and read at count 5.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        #4;
        chk("sim_cnt", 32'(count), 32'd5);
        chk("sim_wp", 32'(write_pointer), 32'd6);
        chk("sim_rp", 32'(read_pointer), 32'd1);
        check_all();
        advance();

        // Reset mid-operation at count 10 with req0 valid.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_cnt", 32'(count), 32'd0);
        chk("mrst_wp", 32'(write_pointer), 32'd0);
        chk("mrst_rp", 32'(read_pointer), 32'd0);
        chk("mrst_load", 32'(load_en), 32'd0);
        chk("mrst_rdy0", 32'(req0_ready), 32'd0);
        chk("mrst_rdv", 32'(rd_valid), 32'd0);
        chk("mrst_opc", 32'(opcode), 32'(ZERO));
        chk("mrst_a", operand_a, 32'd0);
        @(posedge clk);
        #1;
        chk("mrst_nowr", 32'(count), 32'd0);
        do_reset();

        // Randomized traffic: write-heavy, then balanced.
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(0, 99) < 80),
                  1'($urandom_range(0, 99) < 80),
                  1'($urandom_range(0, 99) < 25));
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) < 60));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
